rf_access_sched: RTL and testbench
==================================

// Module: rf_access_sched
// PURPOSE
//  Single-op-per-cycle scheduler in front of the 32x32 register file (rf op 0 = read both ports, op 1 = write).
//  Arbitrates three requesters: writeback (write), decode (rs1/rs2 read pair), debug (read or write).
//  Sequences rf strobes, returns registered read responses and enforces x0 = 0.
//  Sits between decode/writeback/debug and the register file in the core.
// PARAMETERS
//  XLEN            32  data width
//  RAW             5   register index width
//  DBG_STARVE_MAX  8   cycles debug may wait before it gets top priority (1..2**SCW-1)
//  SCW             4   starvation counter width
// PORTS
//  clk            in   1     clock, all state on rising edge
//  rst            in   1     reset, synchronous, active-high
//  wb_valid       in   1     writeback request;  wb_ready out 1 grant pulse
//  wb_rd          in   RAW   writeback destination;  wb_data in XLEN write value
//  dec_valid      in   1     decode read request;  dec_ready out 1 grant pulse
//  dec_rs1/rs2    in   RAW   source indices
//  dec_rsp_valid  out  1     1-cycle pulse, dec_rs1_val/dec_rs2_val (out XLEN) valid
//  dbg_valid      in   1     debug request;  dbg_ready out 1 grant pulse
//  dbg_we         in   1     1 = write, 0 = read;  dbg_addr in RAW;  dbg_wdata in XLEN
//  dbg_rsp_valid  out  1     1-cycle pulse, dbg_rdata (out XLEN) valid (reads only)
//  rf_strobe      out  1     rf access this cycle;  rf_op out 1 (0 read, 1 write)
//  rf_rnum1/2     out  RAW   rf read indices;  rf_wnum out RAW;  rf_wval out XLEN
//  rf_rdata1/2    in   XLEN  rf read data, valid one cycle after a read strobe
// BEHAVIOUR
//  - Reset: state IDLE, starve_cnt 0, every output 0 (all ready/valid/strobe low, data buses 0).
//  - Handshake: requester holds valid + fields stable until ready; ready is a 1-cycle grant, combinational from state/valids.
//  - FSM IDLE: pick one winner, assert its ready and rf_strobe in the same cycle.
//      Priority wb > dec > dbg; if starve_cnt == DBG_STARVE_MAX and dbg_valid, dbg wins outright.
//      Write winner: rf_op=1, rf_wnum/rf_wval driven; stay IDLE.
//      Read winner: rf_op=0, rf_rnum1/2 driven (dbg: both = dbg_addr); record source; -> RD_WAIT.
//  - FSM RD_WAIT (1 cycle): no grants, rf_strobe=0; capture rf_rdata into response regs
//      (index 0 forced to 0); -> IDLE. Response pulse fires the next cycle (grant N -> rsp N+2).
//  - Read throughput: one read per 2 cycles; a grant may coincide with the previous response pulse.
//  - x0: write with index 0 is granted (ready=1) but rf_strobe stays 0; reads of x0 return 0.
//  - starve_cnt: +1 each cycle dbg_valid && !dbg_ready, saturates at DBG_STARVE_MAX; cleared on dbg grant
//      or when dbg_valid is low.
//  - Reset in RD_WAIT: read abandoned, no response pulse, FSM to IDLE.
//  - Requests arriving in RD_WAIT wait; none dropped.
// CONFIGURATION
//  RF_WB_BYPASS_EN defined: in IDLE with wb_valid && dec_valid both granted same cycle:
//    write + read share one strobe (rf_op=1, rf_rnum driven); -> RD_WAIT; any dec source equal to a
//    nonzero wb_rd returns wb_data instead of rf_rdata.
//  RF_WB_BYPASS_EN undefined: wb and dec serialised by priority as above; no forwarding logic.
// TESTING
//  1 rst held 3 cycles then released -> all outputs 0; rf_strobe never 1 during reset.
//  2 wb write x5=0xDEADBEEF, then dec read rs1=5,rs2=0 -> dec_rsp_valid 2 cycles after grant,
//    rs1_val 0xDEADBEEF, rs2_val 0.
//  3 wb write x0=0x1234 -> wb_ready=1, rf_strobe=0; later read x0 -> 0.
//  4 dbg_valid held with wb_valid continuously high -> dbg_ready asserted within DBG_STARVE_MAX+1 cycles.
//  5 wb and dec valid same cycle, dec_rs1=wb_rd=7 -> without bypass: wb first, dec next cycle;
//    with RF_WB_BYPASS_EN: both ready together, rs1_val = wb_data.
//  6 rst asserted in RD_WAIT -> no dec_rsp_valid, next dec request served normally.

Source files
------------

// File: rtl/rf_access_sched.sv
// rf_access_sched
//   One-op-per-cycle scheduler in front of the 32x32 register file.
//   Arbitrates writeback (write), decode (rs1/rs2 read pair) and debug
//   (read or write), drives the rf strobe/op/index/data lines, returns
//   registered read responses and keeps x0 reading as zero.
//
// Ports
//   clk, rst                       clock; synchronous active-high reset
//   wb_valid/wb_rd/wb_data         writeback write request, wb_ready grant
//   dec_valid/dec_rs1/dec_rs2      decode read request, dec_ready grant
//   dec_rsp_valid/dec_rs1_val/dec_rs2_val   decode read response (pulse)
//   dbg_valid/dbg_we/dbg_addr/dbg_wdata     debug request, dbg_ready grant
//   dbg_rsp_valid/dbg_rdata        debug read response (pulse)
//   rf_strobe/rf_op                rf access this cycle, 0 read / 1 write
//   rf_rnum1/rf_rnum2/rf_wnum/rf_wval      rf indices and write data
//   rf_rdata1/rf_rdata2            rf read data, one cycle after a read
//
// Configuration
//   RF_WB_BYPASS_EN  when defined, a writeback and a decode read are
//                    granted together on one strobe and the decode read
//                    forwards the writeback value for matching sources.

module rf_access_sched #(
  parameter int XLEN           = 32,
  parameter int RAW            = 5,
  parameter int DBG_STARVE_MAX = 8,
  parameter int SCW            = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [RAW-1:0]  dec_rs1,
  input  logic [RAW-1:0]  dec_rs2,
  output logic            dec_rsp_valid,
  output logic [XLEN-1:0] dec_rs1_val,
  output logic [XLEN-1:0] dec_rs2_val,
  input  logic            dbg_valid,
  output logic            dbg_ready,
  input  logic            dbg_we,
  input  logic [RAW-1:0]  dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_rsp_valid,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            rf_strobe,
  output logic            rf_op,
  output logic [RAW-1:0]  rf_rnum1,
  output logic [RAW-1:0]  rf_rnum2,
  output logic [RAW-1:0]  rf_wnum,
  output logic [XLEN-1:0] rf_wval,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2
);

  typedef enum logic {IDLE, RD_WAIT} state_e;

  // Context of the read in flight, needed when the rf data comes back.
  typedef struct packed {
    logic           dbg;
    logic [RAW-1:0] rs1;
    logic [RAW-1:0] rs2;
  } rd_ctx_t;

  localparam logic [SCW-1:0] STARVE_MAX = SCW'(DBG_STARVE_MAX);

  state_e          state_q, state_d;
  logic [SCW-1:0]  starve_q, starve_d;
  rd_ctx_t         ctx_q, ctx_d;
  logic            dec_rsp_valid_q, dec_rsp_valid_d;
  logic [XLEN-1:0] dec_rs1_val_q, dec_rs1_val_d;
  logic [XLEN-1:0] dec_rs2_val_q, dec_rs2_val_d;
  logic            dbg_rsp_valid_q, dbg_rsp_valid_d;
  logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;
`ifdef RF_WB_BYPASS_EN
  logic            byp1_q, byp1_d;
  logic            byp2_q, byp2_d;
  logic [XLEN-1:0] byp_data_q, byp_data_d;
`endif

  logic            dbg_starved;
  logic            do_wr, do_rd, rd_dbg, wr_live;
  logic [RAW-1:0]  wr_num, rd_num1, rd_num2;
  logic [XLEN-1:0] wr_val;

  always_comb begin
    state_d         = state_q;
    starve_d        = starve_q;
    ctx_d           = ctx_q;
    dec_rsp_valid_d = 1'b0;
    dbg_rsp_valid_d = 1'b0;
    dec_rs1_val_d   = dec_rs1_val_q;
    dec_rs2_val_d   = dec_rs2_val_q;
    dbg_rdata_d     = dbg_rdata_q;
`ifdef RF_WB_BYPASS_EN
    byp1_d          = byp1_q;
    byp2_d          = byp2_q;
    byp_data_d      = byp_data_q;
`endif
    wb_ready        = 1'b0;
    dec_ready       = 1'b0;
    dbg_ready       = 1'b0;
    do_wr           = 1'b0;
    do_rd           = 1'b0;
    rd_dbg          = 1'b0;
    wr_num          = '0;
    wr_val          = '0;
    rd_num1         = '0;
    rd_num2         = '0;
    dbg_starved     = dbg_valid && (starve_q == STARVE_MAX);

    // Grants are gated by rst so nothing reaches the rf while in reset.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (dbg_starved) begin
            dbg_ready = 1'b1;
          end else if (wb_valid) begin
            wb_ready = 1'b1;
`ifdef RF_WB_BYPASS_EN
            dec_ready = dec_valid;
`endif
          end else if (dec_valid) begin
            dec_ready = 1'b1;
          end else if (dbg_valid) begin
            dbg_ready = 1'b1;
          end
        end
        RD_WAIT: begin
          state_d = IDLE;
          if (ctx_q.dbg) begin
            dbg_rsp_valid_d = 1'b1;
            dbg_rdata_d     = (ctx_q.rs1 == '0) ? '0 : rf_rdata1;
          end else begin
            dec_rsp_valid_d = 1'b1;
`ifdef RF_WB_BYPASS_EN
            // rf read happened on the same strobe as the write, so it
            // returns the old value; substitute the forwarded data.
            dec_rs1_val_d = byp1_q ? byp_data_q :
                            (ctx_q.rs1 == '0) ? '0 : rf_rdata1;
            dec_rs2_val_d = byp2_q ? byp_data_q :
                            (ctx_q.rs2 == '0) ? '0 : rf_rdata2;
`else
            dec_rs1_val_d = (ctx_q.rs1 == '0) ? '0 : rf_rdata1;
            dec_rs2_val_d = (ctx_q.rs2 == '0) ? '0 : rf_rdata2;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Map grants onto a single rf operation.
    if (wb_ready) begin
      do_wr  = 1'b1;
      wr_num = wb_rd;
      wr_val = wb_data;
    end
    if (dbg_ready && dbg_we) begin
      do_wr  = 1'b1;
      wr_num = dbg_addr;
      wr_val = dbg_wdata;
    end
    if (dec_ready) begin
      do_rd   = 1'b1;
      rd_num1 = dec_rs1;
      rd_num2 = dec_rs2;
    end
    if (dbg_ready && !dbg_we) begin
      do_rd   = 1'b1;
      rd_dbg  = 1'b1;
      rd_num1 = dbg_addr;
      rd_num2 = dbg_addr;
    end

    // A write to x0 is accepted but never reaches the rf.
    wr_live   = do_wr && (wr_num != '0);
    rf_strobe = wr_live || do_rd;
    rf_op     = wr_live;
    rf_wnum   = wr_live ? wr_num : '0;
    rf_wval   = wr_live ? wr_val : '0;
    rf_rnum1  = rd_num1;
    rf_rnum2  = rd_num2;

    if (do_rd) begin
      state_d   = RD_WAIT;
      ctx_d.dbg = rd_dbg;
      ctx_d.rs1 = rd_num1;
      ctx_d.rs2 = rd_num2;
`ifdef RF_WB_BYPASS_EN
      byp1_d     = wr_live && (wr_num == rd_num1);
      byp2_d     = wr_live && (wr_num == rd_num2);
      byp_data_d = wr_val;
`endif
    end

    // Debug wait counter: saturating, cleared on grant or idle debug.
    if (!dbg_valid || dbg_ready) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      starve_q        <= '0;
      ctx_q           <= '0;
      dec_rsp_valid_q <= 1'b0;
      dec_rs1_val_q   <= '0;
      dec_rs2_val_q   <= '0;
      dbg_rsp_valid_q <= 1'b0;
      dbg_rdata_q     <= '0;
`ifdef RF_WB_BYPASS_EN
      byp1_q          <= 1'b0;
      byp2_q          <= 1'b0;
      byp_data_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      starve_q        <= starve_d;
      ctx_q           <= ctx_d;
      dec_rsp_valid_q <= dec_rsp_valid_d;
      dec_rs1_val_q   <= dec_rs1_val_d;
      dec_rs2_val_q   <= dec_rs2_val_d;
      dbg_rsp_valid_q <= dbg_rsp_valid_d;
      dbg_rdata_q     <= dbg_rdata_d;
`ifdef RF_WB_BYPASS_EN
      byp1_q          <= byp1_d;
      byp2_q          <= byp2_d;
      byp_data_q      <= byp_data_d;
`endif
    end
  end

  assign dec_rsp_valid = dec_rsp_valid_q;
  assign dec_rs1_val   = dec_rs1_val_q;
  assign dec_rs2_val   = dec_rs2_val_q;
  assign dbg_rsp_valid = dbg_rsp_valid_q;
  assign dbg_rdata     = dbg_rdata_q;

endmodule

// File: tb/tb_rf_access_sched.sv
// tb_rf_access_sched
//   Bench for rf_access_sched: a behavioural register file sits on the rf
//   side, directed scenarios and random traffic drive the three requesters,
//   and a negedge monitor checks grants, rf strobes and read responses
//   against an architectural register model.

module tb_rf_access_sched;
  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int MAX  = 8;
  localparam int SCW  = 4;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            wb_valid, wb_ready;
  logic [RAW-1:0]  wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            dec_valid, dec_ready;
  logic [RAW-1:0]  dec_rs1, dec_rs2;
  logic            dec_rsp_valid;
  logic [XLEN-1:0] dec_rs1_val, dec_rs2_val;
  logic            dbg_valid, dbg_ready, dbg_we;
  logic [RAW-1:0]  dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic            dbg_rsp_valid;
  logic [XLEN-1:0] dbg_rdata;
  logic            rf_strobe, rf_op;
  logic [RAW-1:0]  rf_rnum1, rf_rnum2, rf_wnum;
  logic [XLEN-1:0] rf_wval, rf_rdata1, rf_rdata2;

  rf_access_sched #(.XLEN(XLEN), .RAW(RAW), .DBG_STARVE_MAX(MAX), .SCW(SCW)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rsp_valid(dec_rsp_valid), .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rsp_valid(dbg_rsp_valid), .dbg_rdata(dbg_rdata),
    .rf_strobe(rf_strobe), .rf_op(rf_op), .rf_rnum1(rf_rnum1), .rf_rnum2(rf_rnum2),
    .rf_wnum(rf_wnum), .rf_wval(rf_wval), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
  );

  // Register file behind the scheduler. Reads return the pre-write value;
  // outside a strobe the read bus carries junk.
  logic [XLEN-1:0] mem [32];
  always @(posedge clk) begin
    if (rf_strobe) begin
      rf_rdata1 <= mem[rf_rnum1];
      rf_rdata2 <= mem[rf_rnum2];
      if (rf_op) mem[rf_wnum] <= rf_wval;
    end else begin
      rf_rdata1 <= $urandom;
      rf_rdata2 <= $urandom;
    end
  end

  int cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  typedef struct {
    int              cyc;
    logic [XLEN-1:0] v1;
    logic [XLEN-1:0] v2;
  } exp_t;

  exp_t            dec_q[$];
  exp_t            dbg_q[$];
  logic [XLEN-1:0] ref_rf [32];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Written by the main process only.
  int    p_wb = 0, p_dec = 0, p_dbg = 0;
  bit    starve_test = 1'b0;
  bit    item5_armed = 1'b0;
  int    tmo_cnt = 0;
  string tmo_what = "";

  // Written by the monitor only.
  bit g_wb = 1'b0, g_dec = 1'b0, g_dbg = 1'b0;
  int tmo_reported = 0;
  int last_wb_cyc = 0;
  int dbg_age = 0;
  int dbg_wait = 0;
  bit busy = 1'b0;

  always @(negedge clk) begin
    logic            ewb, edec, edbg;
    logic            wr, rd, exp_op;
    logic [RAW-1:0]  widx, r1, r2;
    logic [XLEN-1:0] wv;
    exp_t            e;

    if (tmo_cnt != tmo_reported) begin
      check(tmo_what, 64'd0, 64'd1);
      tmo_reported++;
    end

    // Responses.
    while (dec_q.size() > 0 && dec_q[0].cyc < cyc) begin
      check("dec_rsp_missing", 64'd0, 64'd1);
      void'(dec_q.pop_front());
    end
    while (dbg_q.size() > 0 && dbg_q[0].cyc < cyc) begin
      check("dbg_rsp_missing", 64'd0, 64'd1);
      void'(dbg_q.pop_front());
    end
    if (!(rst && rst_at_edge)) begin
      if (dec_rsp_valid) begin
        if (dec_q.size() == 0) check("dec_rsp_unexpected", 64'd1, 64'd0);
        else begin
          e = dec_q.pop_front();
          check("dec_rsp_cycle", 64'(cyc), 64'(e.cyc));
          check("dec_rs1_val", 64'(dec_rs1_val), 64'(e.v1));
          check("dec_rs2_val", 64'(dec_rs2_val), 64'(e.v2));
        end
      end
      if (dbg_rsp_valid) begin
        if (dbg_q.size() == 0) check("dbg_rsp_unexpected", 64'd1, 64'd0);
        else begin
          e = dbg_q.pop_front();
          check("dbg_rsp_cycle", 64'(cyc), 64'(e.cyc));
          check("dbg_rdata", 64'(dbg_rdata), 64'(e.v1));
        end
      end
    end

    if (rst) begin
      if (rst_at_edge) begin
        check("rst_ctrl", 64'({wb_ready, dec_ready, dbg_ready, dec_rsp_valid,
                               dbg_rsp_valid, rf_strobe, rf_op}), 64'd0);
        check("rst_idx", 64'({rf_rnum1, rf_rnum2, rf_wnum}), 64'd0);
        check("rst_wval", 64'(rf_wval), 64'd0);
        check("rst_dec_vals", {dec_rs1_val, dec_rs2_val}, 64'd0);
        check("rst_dbg_rdata", 64'(dbg_rdata), 64'd0);
      end else begin
        check("rst_no_grant", 64'({wb_ready, dec_ready, dbg_ready, rf_strobe}), 64'd0);
      end
      dec_q.delete();
      dbg_q.delete();
      busy     = 1'b0;
      dbg_wait = 0;
      dbg_age  = 0;
      g_wb = 1'b0; g_dec = 1'b0; g_dbg = 1'b0;
    end else begin
      // Arbitration rule: nothing while a read is waiting on the rf,
      // otherwise a debug requester that has waited MAX cycles wins,
      // else writeback > decode > debug.
      ewb = 1'b0; edec = 1'b0; edbg = 1'b0;
      if (!busy) begin
        if (dbg_valid && dbg_wait >= MAX) edbg = 1'b1;
        else if (wb_valid) begin
          ewb  = 1'b1;
          edec = BYP && dec_valid;
        end
        else if (dec_valid) edec = 1'b1;
        else if (dbg_valid) edbg = 1'b1;
      end
      check("grants", 64'({wb_ready, dec_ready, dbg_ready}), 64'({ewb, edec, edbg}));
      busy = edec || (edbg && !dbg_we);
      dbg_wait = (dbg_valid && !edbg) ? ((dbg_wait < MAX) ? dbg_wait + 1 : MAX) : 0;

      g_wb = wb_ready; g_dec = dec_ready; g_dbg = dbg_ready;

      if (wb_ready) last_wb_cyc = cyc;
      if (dec_ready && item5_armed)
        check("wb_dec_order", 64'(cyc - last_wb_cyc), BYP ? 64'd0 : 64'd1);

      if (dbg_valid) begin
        if (dbg_ready) begin
          if (starve_test) check("dbg_starve_bound", 64'(dbg_age <= MAX), 64'd1);
          dbg_age = 0;
        end else dbg_age++;
      end else dbg_age = 0;

      // rf strobe for whatever was granted this cycle.
      wr = 1'b0; rd = 1'b0; widx = '0; wv = '0; r1 = '0; r2 = '0;
      if (wb_ready) begin wr = 1'b1; widx = wb_rd; wv = wb_data; end
      if (dbg_ready && dbg_we) begin wr = 1'b1; widx = dbg_addr; wv = dbg_wdata; end
      if (dec_ready) begin rd = 1'b1; r1 = dec_rs1; r2 = dec_rs2; end
      if (dbg_ready && !dbg_we) begin rd = 1'b1; r1 = dbg_addr; r2 = dbg_addr; end
      exp_op = wr && (widx != 0);
      check("rf_strobe_op", 64'({rf_strobe, rf_op}), 64'({exp_op || rd, exp_op}));
      if (exp_op) check("rf_write", 64'({rf_wnum, rf_wval}), 64'({widx, wv}));
      if (rd) check("rf_read_idx", 64'({rf_rnum1, rf_rnum2}), 64'({r1, r2}));

      // Architectural effect: writes land first, then reads see them.
      if (exp_op) ref_rf[widx] = wv;
      if (dec_ready) begin
        e.cyc = cyc + 2; e.v1 = ref_rf[dec_rs1]; e.v2 = ref_rf[dec_rs2];
        dec_q.push_back(e);
      end
      if (dbg_ready && !dbg_we) begin
        e.cyc = cyc + 2; e.v1 = ref_rf[dbg_addr]; e.v2 = '0;
        dbg_q.push_back(e);
      end
    end
  end

  function automatic logic [RAW-1:0] ridx();
    return ($urandom_range(1) == 1) ? RAW'($urandom_range(7)) : RAW'($urandom_range(31));
  endfunction

  // One clock: drop granted requests, optionally issue random new ones.
  task automatic step();
    @(posedge clk);
    #1;
    if (g_wb)  wb_valid  = 1'b0;
    if (g_dec) dec_valid = 1'b0;
    if (g_dbg) dbg_valid = 1'b0;
    if (!wb_valid && $urandom_range(99) < p_wb) begin
      wb_valid = 1'b1; wb_rd = ridx(); wb_data = $urandom;
    end
    if (!dec_valid && $urandom_range(99) < p_dec) begin
      dec_valid = 1'b1; dec_rs1 = ridx(); dec_rs2 = ridx();
    end
    if (!dbg_valid && $urandom_range(99) < p_dbg) begin
      dbg_valid = 1'b1; dbg_we = 1'($urandom_range(1)); dbg_addr = ridx(); dbg_wdata = $urandom;
    end
  endtask

  task automatic wait_grant(input int which, input string nm);
    for (int i = 0; i < 40; i++) begin
      step();
      if ((which == 0 && !wb_valid) || (which == 1 && !dec_valid) ||
          (which == 2 && !dbg_valid)) return;
    end
    tmo_what = nm;
    tmo_cnt++;
    wb_valid = 1'b0; dec_valid = 1'b0; dbg_valid = 1'b0;
  endtask

  task automatic drain();
    p_wb = 0; p_dec = 0; p_dbg = 0;
    for (int i = 0; i < 60; i++) begin
      if (!wb_valid && !dec_valid && !dbg_valid && dec_q.size() == 0 && dbg_q.size() == 0)
        return;
      step();
    end
    tmo_what = "drain_timeout";
    tmo_cnt++;
    wb_valid = 1'b0; dec_valid = 1'b0; dbg_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]    = $urandom;
      ref_rf[i] = (i == 0) ? '0 : mem[i];
    end
    rst = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0;
    dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Write x5, read it back with x0 on the other port.
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    wait_grant(0, "wb_x5_timeout");
    dec_valid = 1'b1; dec_rs1 = 5'd5; dec_rs2 = 5'd0;
    wait_grant(1, "dec_x5_timeout");
    drain();

    // x0 writes are swallowed; x0 reads return zero.
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    wait_grant(0, "wb_x0_timeout");
    dec_valid = 1'b1; dec_rs1 = 5'd0; dec_rs2 = 5'd5;
    wait_grant(1, "dec_x0_timeout");
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd0;
    wait_grant(2, "dbg_x0_timeout");
    drain();

    // Debug under continuous writeback pressure.
    starve_test = 1'b1;
    p_wb = 100;
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
    wait_grant(2, "dbg_starve_timeout");
    starve_test = 1'b0;
    drain();

    // Writeback and decode collide on x7.
    step();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFEF00D;
    dec_valid = 1'b1; dec_rs1 = 5'd7; dec_rs2 = 5'd3;
    item5_armed = 1'b1;
    wait_grant(1, "dec_x7_timeout");
    item5_armed = 1'b0;
    drain();

    // Reset while a read is waiting on the rf, then a normal read.
    step();
    dec_valid = 1'b1; dec_rs1 = 5'd5; dec_rs2 = 5'd7;
    wait_grant(1, "dec_pre_rst_timeout");
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    dec_valid = 1'b1; dec_rs1 = 5'd7; dec_rs2 = 5'd5;
    wait_grant(1, "dec_post_rst_timeout");
    drain();

    // Random mixed traffic.
    p_wb = 35; p_dec = 40; p_dbg = 25;
    repeat (3000) step();
    drain();

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
